booth_seq_ctrl: RTL and testbench
=================================

// Module: booth_seq_ctrl
// PURPOSE
//   Sequencer for the 4-bit run-skipping Booth multiplier datapath.
//   - Latches the multiplier on start and scans it LSB-first with implied bit m[-1]=0.
//   - Emits one {shift, op} step per clock, so the datapath jumps over runs of equal bits.
//   - Drives the datapath operand load, holds it frozen via finish, and reports completion.
//   - Cross-checks the datapath's remaining-bit counter when the run completes.
// PARAMETERS
//   W     4  operand width; must equal the datapath width
//   SW    3  width of shift and counter buses; must be clog2(W)+1
// PORTS
//   clk         in   1   single clock; all state changes on rising edge
//   rst         in   1   asynchronous reset, active-high
//   start       in   1   request a multiply; sampled only in IDLE
//   multiplier  in   W   operand B; captured into m_q on accepted start
//   dp_counter  in   SW  datapath remaining-bit counter, used for the end check
//   load        out  1   1 for exactly one cycle (LOAD); top level drives datapath rstn = ~load
//   shift       out  SW  bit positions the datapath shifts this step (0..W)
//   op          out  1   1 = add multiplicand, 0 = subtract; ignored by datapath once counter hits 0
//   finish      out  1   1 = datapath holds its state; 0 only in STEP
//   busy        out  1   1 from accepted start until leaving DONE
//   done        out  1   one-cycle pulse in DONE; {C,B} result is valid from then on
//   err         out  1   sticky: dp_counter != 0 in DONE; cleared on next accepted start
// BEHAVIOUR
//   Reset (async, any state, including mid-operation):
//     - state=IDLE; load=0, shift=0, op=0, finish=1, busy=0, done=0, err=0; m_q=0, cur=0.
//   All outputs are registered, so they are stable a full cycle before the datapath edge.
//   IDLE
//     - start=1 -> LOAD; capture m_q=multiplier, cur=0, clear err.
//     - start while busy is ignored.
//   LOAD (1 cycle): load=1, finish=1, busy=1. Next state is STEP with the first step registered.
//   STEP (finish=0): each cycle presents one step.
//     - Search: smallest j with cur <= j <= W-1 and m_q[j] != m_q[j-1] (m_q[-1] = 0).
//     - Found: shift = j-cur; op = ~m_q[j]; cur <= j; remain in STEP.
//         (01 pair -> op=1 add; 10 pair -> op=0 subtract.)
//     - Not found: final step, shift = W-cur, op=0; next state DONE.
//     - The search start is cur+1 after any op step; cur itself only starts the first search.
//     - The first step may have shift=0 (when m_q[0]=1). The final shift is always >= 1.
//     - Step count = (number of transitions) + 1, in the range 1..W+1.
//   DONE (1 cycle): finish=1, done=1, shift=0, op=0.
//     - err <= (dp_counter != 0).
//     - Next state IDLE; busy drops on entry to IDLE.
//   Latency: start edge -> done = 2 + steps cycles; worst case W+3.
//   Arithmetic: search and subtraction are unsigned on SW bits; cur never exceeds W-1.
//   The multiplier input may change after start; only m_q is used.
// TESTING
//   1. mult=4'b0011, mcand=5, start -> steps (shift,op)=(0,0),(2,1),(2,0);
//      dp_counter 4,4,2,0; done at cycle 5; result=8'h0F; err=0.
//   2. mult=4'b0000, mcand=7 -> single step (4,0); done at cycle 3; result=8'h00.
//   3. mult=4'b1010 (-6), mcand=3 -> steps (1,0),(1,1),(1,0),(1,0); result=8'hEE.
//   4. mult=4'b0101, mcand=-2 -> steps (0,0),(1,1),(1,0),(1,1),(1,0);
//      done at cycle 7 (W+3); result=8'hF6.
//   5. rst asserted during the 2nd STEP of case 1 -> immediately finish=1, busy=0, shift=0;
//      then a start with mult=4'b0011 reproduces case 1 exactly.
//   6. start held high through a run, and dp_counter forced to 1 in DONE ->
//      no restart while busy; err=1 and stays set until the next accepted start.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// Step sequencer for the run-skipping Booth multiplier datapath.
// Scans the latched multiplier LSB-first and issues one {shift, op} step per clock.
module booth_seq_ctrl #(
    parameter int unsigned W  = 4,
    parameter int unsigned SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [W-1:0]  i_multiplier,
    input  logic [SW-1:0] i_dp_counter,
    output logic          o_load,
    output logic [SW-1:0] o_shift,
    output logic          o_op,
    output logic          o_finish,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_m;
    logic [SW-1:0] r_cur;
    logic          r_first;
    logic          r_last;

    logic [W-1:0]  w_trans;
    logic [SW-1:0] w_from;
    logic [SW-1:0] w_j;
    logic          w_found;
    logic          w_jbit;
    logic          w_accept;
    logic          w_adv;
    logic [SW-1:0] w_step_shift;
    logic          w_step_op;

    logic          w_load_nxt;
    logic [SW-1:0] w_shift_nxt;
    logic          w_op_nxt;
    logic          w_finish_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_err_nxt;

    // bit j differs from bit j-1, with an implied zero below bit 0
    assign w_trans  = r_m ^ {r_m[W-2:0], 1'b0};
    assign w_from   = r_first ? r_cur : r_cur + SW'(1);
    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_adv    = (r_state == S_LOAD) || ((r_state == S_STEP) && !r_last);

    // Find the next run boundary at or above the search start
    always_comb begin
        w_found = 1'b0;
        w_j     = '0;
        w_jbit  = 1'b0;
        for (int unsigned j = 0; j < W; j++) begin
            if (!w_found && w_trans[j] && (SW'(j) >= w_from)) begin
                w_found = 1'b1;
                w_j     = SW'(j);
                w_jbit  = r_m[j];
            end
        end
        w_step_shift = w_found ? (w_j - r_cur) : (SW'(W) - r_cur);
        w_step_op    = w_found & ~w_jbit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_STEP;
            S_STEP:  if (r_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state and registered with it
    always_comb begin
        w_load_nxt   = (w_state_nxt == S_LOAD);
        w_finish_nxt = (w_state_nxt != S_STEP);
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_done_nxt   = (w_state_nxt == S_DONE);
        w_shift_nxt  = '0;
        w_op_nxt     = 1'b0;
        if (w_state_nxt == S_STEP) begin
            w_shift_nxt = w_step_shift;
            w_op_nxt    = w_step_op;
        end
        w_err_nxt = o_err;
        if (w_accept) begin
            w_err_nxt = 1'b0;
        end else if (r_state == S_DONE) begin
            w_err_nxt = (i_dp_counter != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_load   <= 1'b0;
            o_shift  <= '0;
            o_op     <= 1'b0;
            o_finish <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            r_m      <= '0;
            r_cur    <= '0;
            r_first  <= 1'b1;
            r_last   <= 1'b0;
        end else begin
            o_load   <= w_load_nxt;
            o_shift  <= w_shift_nxt;
            o_op     <= w_op_nxt;
            o_finish <= w_finish_nxt;
            o_busy   <= w_busy_nxt;
            o_done   <= w_done_nxt;
            o_err    <= w_err_nxt;
            if (w_accept) begin
                r_m     <= i_multiplier;
                r_cur   <= '0;
                r_first <= 1'b1;
                r_last  <= 1'b0;
            end else if (w_adv) begin
                // r_last marks that the step just registered is the closing one
                if (w_found) r_cur <= w_j;
                r_first <= 1'b0;
                r_last  <= ~w_found;
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: timeline model of each multiply, directed cases and random runs.
module tb_booth_seq_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned SW = 3;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic [W-1:0]  i_multiplier;
    logic [SW-1:0] i_dp_counter;
    logic          o_load;
    logic [SW-1:0] o_shift;
    logic          o_op;
    logic          o_finish;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    booth_seq_ctrl #(.W(W), .SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_multiplier (i_multiplier),
        .i_dp_counter (i_dp_counter),
        .o_load       (o_load),
        .o_shift      (o_shift),
        .o_op         (o_op),
        .o_finish     (o_finish),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic        force_dp = 1'b0;
    int          mk = 0;
    int          mn = 0;
    logic [31:0] mt = '0;
    logic        m_err = 1'b0;
    logic        observing = 1'b0;
    int          obs_cnt = 0;
    int          obs_n = 0;
    int          obs_lat = 0;
    logic [31:0] obs_trace = '0;
    logic        obs_done = 1'b0;

    logic          e_load, e_op, e_finish, e_busy, e_done;
    logic [SW-1:0] e_shift;
    logic [3:0]    nib;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Step list as nibbles {shift,op}: one per run boundary, then the closing step
    function automatic logic [31:0] model_trace(input logic [W-1:0] m, output int n);
        logic [W:0]  ext;
        logic [31:0] t;
        int          prev;
        ext  = {m, 1'b0};
        t    = '0;
        prev = 0;
        n    = 0;
        for (int j = 0; j < int'(W); j++) begin
            if (ext[j+1] != ext[j]) begin
                t    = (t << 4) | {28'd0, 3'(j - prev), ~m[j]};
                prev = j;
                n++;
            end
        end
        t = (t << 4) | {28'd0, 3'(int'(W) - prev), 1'b0};
        n++;
        return t;
    endfunction

    // Datapath stand-in: remaining-bit counter, optionally corrupted in DONE
    initial begin
        i_dp_counter = '0;
        forever begin
            @(negedge clk);
            if (o_load) i_dp_counter = SW'(W);
            else if (!o_finish) i_dp_counter = i_dp_counter - o_shift;
            else if (o_done && force_dp) i_dp_counter = SW'(1);
        end
    end

    // Per-cycle compare against the timeline model, then advance it
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mk = 0;
                m_err = 1'b0;
                observing = 1'b0;
                check("rst_load",   32'(o_load),   32'd0);
                check("rst_shift",  32'(o_shift),  32'd0);
                check("rst_op",     32'(o_op),     32'd0);
                check("rst_finish", 32'(o_finish), 32'd1);
                check("rst_busy",   32'(o_busy),   32'd0);
                check("rst_done",   32'(o_done),   32'd0);
                check("rst_err",    32'(o_err),    32'd0);
                continue;
            end
            e_load   = (mk == 1);
            e_busy   = (mk != 0);
            e_done   = (mk != 0) && (mk == mn + 2);
            e_finish = !((mk >= 2) && (mk <= mn + 1));
            e_shift  = '0;
            e_op     = 1'b0;
            if (!e_finish) begin
                nib     = 4'(mt >> (4 * (mn - 1 - (mk - 2))));
                e_shift = nib[3:1];
                e_op    = nib[0];
            end
            check("load",   32'(o_load),   32'(e_load));
            check("shift",  32'(o_shift),  32'(e_shift));
            check("op",     32'(o_op),     32'(e_op));
            check("finish", 32'(o_finish), 32'(e_finish));
            check("busy",   32'(o_busy),   32'(e_busy));
            check("done",   32'(o_done),   32'(e_done));
            check("err",    32'(o_err),    32'(m_err));
            if (observing) begin
                obs_cnt++;
                if (!o_finish) begin
                    obs_trace = (obs_trace << 4) | {28'd0, o_shift, o_op};
                    obs_n++;
                end
                if (o_done) begin
                    obs_lat   = obs_cnt;
                    obs_done  = 1'b1;
                    observing = 1'b0;
                end
            end
            if (mk == 0) begin
                if (i_start) begin
                    mt        = model_trace(i_multiplier, mn);
                    mk        = 1;
                    m_err     = 1'b0;
                    observing = 1'b1;
                    obs_cnt   = 0;
                    obs_n     = 0;
                    obs_trace = '0;
                end
            end else if (mk == mn + 2) begin
                m_err = (i_dp_counter != '0);
                mk    = 0;
            end else begin
                mk++;
            end
        end
    end

    task automatic wait_done();
        for (int c = 0; c < 20 && !obs_done; c++) begin
            @(posedge clk);
            #2;
        end
        check("done_timeout", 32'(obs_done), 32'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            if (!o_busy) break;
        end
        check("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    task automatic pulse_start(input logic [W-1:0] m);
        @(posedge clk);
        #2;
        obs_done     = 1'b0;
        i_start      = 1'b1;
        i_multiplier = m;
        @(posedge clk);
        #2;
        i_start      = 1'b0;
        i_multiplier = W'($urandom);
    endtask

    task automatic run_case(input string name, input logic [W-1:0] m,
                            input logic [31:0] etr, input int en, input int elat);
        pulse_start(m);
        wait_done();
        if (obs_done) begin
            check({name, "_trace"}, obs_trace, etr);
            check({name, "_steps"}, 32'(obs_n), 32'(en));
            check({name, "_lat"},   32'(obs_lat), 32'(elat));
        end
    endtask

    int          pn;
    logic [31:0] pt;

    initial begin
        rst          = 1'b1;
        i_start      = 1'b0;
        i_multiplier = '0;

        pt = model_trace(4'b0011, pn); check("model_0011", pt, 32'h054);   check("model_0011_n", 32'(pn), 32'd3);
        pt = model_trace(4'b0000, pn); check("model_0000", pt, 32'h8);     check("model_0000_n", 32'(pn), 32'd1);
        pt = model_trace(4'b1010, pn); check("model_1010", pt, 32'h2322);  check("model_1010_n", 32'(pn), 32'd4);
        pt = model_trace(4'b0101, pn); check("model_0101", pt, 32'h03232); check("model_0101_n", 32'(pn), 32'd5);

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        run_case("case1", 4'b0011, 32'h054,   3, 5);
        check("case1_err", 32'(o_err), 32'd0);
        run_case("case2", 4'b0000, 32'h8,     1, 3);
        run_case("case3", 4'b1010, 32'h2322,  4, 6);
        run_case("case4", 4'b0101, 32'h03232, 5, 7);

        // Reset in the second step of a run, then the same run again
        pulse_start(4'b0011);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_finish", 32'(o_finish), 32'd1);
        check("midrst_busy",   32'(o_busy),   32'd0);
        check("midrst_shift",  32'(o_shift),  32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_case("case5", 4'b0011, 32'h054, 3, 5);

        // Bad counter at completion: err sticks until the next accepted start
        force_dp = 1'b1;
        run_case("case6", 4'b0011, 32'h054, 3, 5);
        force_dp = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("err_sticky", 32'(o_err), 32'd1);
        i_start      = 1'b1;
        i_multiplier = 4'b0000;
        repeat (12) @(posedge clk);
        #2;
        i_start = 1'b0;
        wait_idle();
        check("err_cleared", 32'(o_err), 32'd0);

        for (int it = 0; it < 40; it++) begin
            force_dp = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #2;
                i_start = 1'b1;
                for (int c = 0; c < int'($urandom_range(5, 20)); c++) begin
                    i_multiplier = W'($urandom);
                    @(posedge clk);
                    #2;
                end
                i_start = 1'b0;
                wait_idle();
            end else begin
                pulse_start(W'($urandom));
                if ($urandom_range(0, 9) == 0) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    #2;
                    rst = 1'b1;
                    @(posedge clk);
                    #2;
                    rst = 1'b0;
                end
                wait_idle();
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        force_dp = 1'b0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
